demux_1_4_stream: RTL and testbench

- Registered 1-to-4 demultiplexer for a valid/ready stream; the inverse of the team's 4:1 mux blocks.
- A single input word is routed to one of four output channels. The channel is chosen either by an explicit in_sel or by an internal round-robin pointer.
- Each output channel has a one-entry holding register, so downstream consumers can stall independently.
- Sits between a shared producer and four independent consumers in the lab datapath.

---
 rtl/demux_1_4_stream.sv | 65 ++++++
 tb/tb_demux_1_4_stream.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/demux_1_4_stream.sv
// Registered 1-to-4 valid/ready demultiplexer. Each output channel has a
// one-entry holding register, so each consumer can stall without blocking the others.
module demux_1_4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             auto_rr,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [1:0]       rr_ptr
);

  logic [1:0]       ch;
  logic             accept;
  logic [3:0]       load;
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [1:0]       ptr_q;

  assign ch       = auto_rr ? ptr_q : in_sel;
  // The target channel can take a word if it is empty or is being drained this cycle.
  assign in_ready = !valid_q[ch] | out_ready[ch];
  assign accept   = in_valid & in_ready;

  always_comb begin
    load    = 4'b0000;
    valid_d = valid_q;
    for (int k = 0; k < 4; k++) begin
      load[k]    = accept && (ch == 2'(k));
      valid_d[k] = load[k] | (valid_q[k] & ~out_ready[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 4'b0000;
      ptr_q   <= 2'd0;
      for (int k = 0; k < 4; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < 4; k++) begin
        if (load[k]) data_q[k] <= in_data;
      end
      if (accept && auto_rr) ptr_q <= ptr_q + 2'd1;
    end
  end

  assign out_valid = valid_q;
  assign out_data0 = data_q[0];
  assign out_data1 = data_q[1];
  assign out_data2 = data_q[2];
  assign out_data3 = data_q[3];
  assign rr_ptr    = ptr_q;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// Scoreboard bench for demux_1_4_stream: stimulus pushes expected words per
// channel, a negedge monitor compares held words and pops them on drain.
module tb_demux_1_4_stream;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_sel = 2'd0;
  logic             auto_rr = 1'b0;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = 4'b1111;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0]       rr_ptr;
  logic [WIDTH-1:0] od [4];

  int compared = 0;
  int mismatched = 0;
  logic [WIDTH-1:0] sbq [4][$];

  demux_1_4_stream #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .auto_rr(auto_rr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3), .rr_ptr(rr_ptr)
  );

  assign od[0] = out_data0;
  assign od[1] = out_data1;
  assign od[2] = out_data2;
  assign od[3] = out_data3;

  always #5 clk = ~clk;

  // Monitor: a channel must be valid exactly when the scoreboard holds a word for it.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        compared++;
        if (out_valid[k] !== (sbq[k].size() != 0)) begin
          mismatched++;
          $display("FAIL valid_ch%0d: got %b expected %b", k, out_valid[k], sbq[k].size() != 0);
        end
        if (out_valid[k] === 1'b1 && sbq[k].size() != 0) begin
          compared++;
          if (od[k] !== sbq[k][0]) begin
            mismatched++;
            $display("FAIL data_ch%0d: got %h expected %h", k, od[k], sbq[k][0]);
          end
          if (out_ready[k]) void'(sbq[k].pop_front());
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; presents one word for a cycle.
  task automatic send(input logic [WIDTH-1:0] d, input logic [1:0] sel,
                      input logic exp_ready, input int exp_ch);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = sel;
    @(negedge clk);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    if (exp_ready) sbq[exp_ch].push_back(d);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_rr_ptr", 32'(rr_ptr), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_data", {out_data3, out_data2, out_data1, out_data0}, 32'h0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // explicit mode, back to back
    send(4'ha, 2'd0, 1'b1, 0);
    send(4'hb, 2'd1, 1'b1, 1);
    send(4'hc, 2'd2, 1'b1, 2);
    send(4'hd, 2'd3, 1'b1, 3);
    idle(2);

    // stall and hold on channel 2
    out_ready = 4'b0000;
    send(4'h7, 2'd2, 1'b1, 2);
    send(4'h3, 2'd2, 1'b0, 2);
    send(4'h3, 2'd2, 1'b0, 2);
    chk("hold_data2", 32'(out_data2), 32'h7);
    out_ready = 4'b0100;
    send(4'h3, 2'd2, 1'b1, 2);
    out_ready = 4'b0000;
    idle(1);
    chk("reload_data2", 32'(out_data2), 32'h3);
    chk("reload_valid2", 32'(out_valid[2]), 32'h1);

    // isolation: channel 1 full and stalled
    send(4'h9, 2'd1, 1'b1, 1);
    send(4'h5, 2'd0, 1'b1, 0);
    idle(1);
    chk("iso_valid", 32'(out_valid), 32'h7);
    chk("iso_data1", 32'(out_data1), 32'h9);
    chk("iso_data0", 32'(out_data0), 32'h5);
    out_ready = 4'b1111;
    idle(2);

    // round-robin wrap, in_sel deliberately pointing elsewhere
    chk("rr_start", 32'(rr_ptr), 32'h0);
    auto_rr = 1'b1;
    for (int i = 1; i <= 6; i++) send(4'(i), 2'd3, 1'b1, (i - 1) % 4);
    idle(2);
    chk("rr_wrap_ptr", 32'(rr_ptr), 32'h2);

    // round-robin stall on a full channel 3
    out_ready = 4'b0000;
    auto_rr = 1'b0;
    send(4'h8, 2'd3, 1'b1, 3);
    chk("rr_hold_explicit", 32'(rr_ptr), 32'h2);
    auto_rr = 1'b1;
    send(4'he, 2'd0, 1'b1, 2);
    chk("rr_ptr_3", 32'(rr_ptr), 32'h3);
    send(4'hf, 2'd0, 1'b0, 3);
    chk("rr_stall_ptr_a", 32'(rr_ptr), 32'h3);
    send(4'hf, 2'd0, 1'b0, 3);
    chk("rr_stall_ptr_b", 32'(rr_ptr), 32'h3);
    out_ready = 4'b1000;
    send(4'hf, 2'd0, 1'b1, 3);
    out_ready = 4'b0000;
    idle(1);
    chk("rr_after_stall", 32'(rr_ptr), 32'h0);

    // async reset with out_valid = 1011
    out_ready = 4'b0100;
    idle(1);
    out_ready = 4'b0000;
    send(4'h1, 2'd0, 1'b1, 0);
    send(4'h2, 2'd0, 1'b1, 1);
    in_valid = 1'b0;
    chk("pre_rst_valid", 32'(out_valid), 32'hb);
    chk("pre_rst_ptr", 32'(rr_ptr), 32'h2);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) sbq[k].delete();
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_data", {out_data3, out_data2, out_data1, out_data0}, 32'h0);
    chk("arst_ptr", 32'(rr_ptr), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    idle(2);
    chk("post_rst_valid", 32'(out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
